// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive/loader path.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned NUM_WORDS_DEF    = 768;
    localparam int unsigned ADDR_W_DEF       = 12;
    localparam int unsigned TIMEOUT_BITS_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 bit sampler: synchronizer, mid-bit timer and shift register.
// Emits a one-cycle byte_valid (good stop bit) or byte_err (low stop bit).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic       o_byte_valid,
    output logic       o_byte_err,
    output logic [7:0] o_byte
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        r_state, w_state_n;
    logic             r_sync1, r_rxd;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_bit, w_bit_n;
    logic [7:0]       r_shift, w_shift_n;
    logic             r_valid, w_valid_n;
    logic             r_err, w_err_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rxd   <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= i_rxd;
            r_rxd   <= r_sync1;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_valid <= w_valid_n;
            r_err   <= w_err_n;
        end
    end

    // Start bit re-checked at its midpoint; later samples one bit period apart.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_err_n   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_n = '0;
                if (!r_rxd) w_state_n = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = r_rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_shift_n = {r_rxd, r_shift[7:1]};
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = RX_IDLE;
                    w_valid_n = r_rxd;
                    w_err_n   = ~r_rxd;
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    assign o_byte_valid = r_valid;
    assign o_byte_err   = r_err;
    assign o_byte       = r_shift;

endmodule

// File: rtl/uart_rx_loader.sv
// Assembles UART bytes into 32-bit words and writes them to sequential RAM addresses.
// Optional partial-word idle timeout enabled by defining RX_TIMEOUT_EN.
module uart_rx_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned NUM_WORDS    = NUM_WORDS_DEF,
`ifdef RX_TIMEOUT_EN
    parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEF,
`endif
    parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              UART_RXD,
    input  logic              START,
    input  logic              STOP,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [31:0]       WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              FRAME_ERR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic        w_byte_valid, w_byte_err, w_timeout;
    logic [7:0]  w_byte;

    load_state_e       r_state, w_state_n;
    logic [1:0]        r_lane, w_lane_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic [23:0]       r_word, w_word_n;
    logic              r_wr_en, w_wr_en_n;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_n;
    logic [31:0]       r_wr_data, w_wr_data_n;
    logic              r_ferr, w_ferr_n;
    logic              r_busy, r_done;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .i_clk        (CLOCK),
        .i_rst        (RESET),
        .i_rxd        (UART_RXD),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err),
        .o_byte       (w_byte)
    );

`ifdef RX_TIMEOUT_EN
    localparam int unsigned      TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned      TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Idle cycles since the last byte while a word is partially filled.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_to_cnt <= '0;
        end else if (r_state != ST_LOAD || r_lane == 2'd0 || w_byte_valid || STOP) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_lane != 2'd0) && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_lane    <= '0;
            r_addr    <= '0;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_lane    <= w_lane_n;
            r_addr    <= w_addr_n;
            r_word    <= w_word_n;
            r_wr_en   <= w_wr_en_n;
            r_wr_addr <= w_wr_addr_n;
            r_wr_data <= w_wr_data_n;
            r_ferr    <= w_ferr_n;
            r_busy    <= (r_state == ST_LOAD);
            r_done    <= (r_state == ST_DONE);
        end
    end

    // STOP overrides everything, including a byte landing in the same cycle.
    always_comb begin
        w_state_n   = r_state;
        w_lane_n    = r_lane;
        w_addr_n    = r_addr;
        w_word_n    = r_word;
        w_wr_en_n   = 1'b0;
        w_wr_addr_n = r_wr_addr;
        w_wr_data_n = r_wr_data;
        w_ferr_n    = r_ferr;
        if (STOP) begin
            w_state_n = ST_IDLE;
            w_lane_n  = '0;
            w_addr_n  = '0;
            w_word_n  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        w_state_n = ST_LOAD;
                        w_lane_n  = '0;
                        w_addr_n  = '0;
                        w_word_n  = '0;
                        w_ferr_n  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_byte_err) begin
                        w_ferr_n = 1'b1;
                    end else if (w_byte_valid) begin
                        w_lane_n = r_lane + 2'd1;
                        case (r_lane)
                            2'd0: w_word_n[7:0]   = w_byte;
                            2'd1: w_word_n[15:8]  = w_byte;
                            2'd2: w_word_n[23:16] = w_byte;
                            default: begin
                                w_wr_en_n   = 1'b1;
                                w_wr_addr_n = r_addr;
                                w_wr_data_n = {w_byte, r_word};
                                w_addr_n    = r_addr + 1'b1;
                                if (r_addr == LAST_ADDR) w_state_n = ST_DONE;
                            end
                        endcase
                    end else if (w_timeout) begin
                        w_lane_n = '0;
                        w_word_n = '0;
                    end
                end
                ST_DONE: w_state_n = ST_IDLE;
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    assign WR_EN     = r_wr_en;
    assign WR_ADDR   = r_wr_addr;
    assign WR_DATA   = r_wr_data;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign FRAME_ERR = r_ferr;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed testbench for uart_rx_loader (small CLKS_PER_BIT and NUM_WORDS).
// The idle-timeout step runs only when RX_TIMEOUT_EN is defined.
module tb_uart_rx_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned NW  = 4;
    localparam int unsigned AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy, done, frame_err;

    int n_checks = 0;
    int n_errors = 0;

    int            cyc = 0;
    logic [31:0]   wr_data_log[$];
    logic [31:0]   wr_addr_log[$];
    int            wr_cyc_log[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          done_busy = 1'b1;

    always #5 clk = ~clk;

    uart_rx_loader #(
        .CLKS_PER_BIT (CPB),
        .NUM_WORDS    (NW),
        .ADDR_W       (AW)
    ) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .UART_RXD  (rxd),
        .START     (start),
        .STOP      (stop),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .BUSY      (busy),
        .DONE      (done),
        .FRAME_ERR (frame_err)
    );

    // Write/DONE monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            wr_data_log.push_back(wr_data);
            wr_addr_log.push_back(32'(wr_addr));
            wr_cyc_log.push_back(cyc);
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_busy <= busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_data(input int idx);
        if (idx < wr_data_log.size()) return wr_data_log[idx];
        return 'x;
    endfunction

    function automatic logic [31:0] log_addr(input int idx);
        if (idx < wr_addr_log.size()) return wr_addr_log[idx];
        return 'x;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        if (good) begin
            drive_bit(1'b1, CPB);
        end else begin
            drive_bit(1'b0, CPB / 2 + 4);
            drive_bit(1'b1, 2 * CPB);
        end
    endtask

    task automatic idle_bits(input int n);
        drive_bit(1'b1, n * CPB);
    endtask

    task automatic pulse(input logic s, input logic p);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int last;
        logic [7:0] b;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word
        pulse(1'b1, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        base = wr_data_log.size();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle_bits(2);
        check("w1_count", 32'(wr_data_log.size() - base), 32'd1);
        check("w1_addr", log_addr(base), 32'd0);
        check("w1_data", log_data(base), 32'h44332211);
        check("w1_busy", 32'(busy), 32'd1);
        check("w1_no_done", 32'(done_cnt), 32'd0);
        check("w1_hold_addr", 32'(wr_addr), 32'd0);
        check("w1_hold_data", wr_data, 32'h44332211);

        // Full frame, back-to-back bytes
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        base = wr_data_log.size();
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            send_byte(b, 1'b1);
        end
        idle_bits(2);
        check("fr_count", 32'(wr_data_log.size() - base), 32'd4);
        check("fr_addr0", log_addr(base), 32'd0);
        check("fr_data0", log_data(base), 32'h03020100);
        check("fr_addr1", log_addr(base + 1), 32'd1);
        check("fr_data1", log_data(base + 1), 32'h07060504);
        check("fr_addr2", log_addr(base + 2), 32'd2);
        check("fr_data2", log_data(base + 2), 32'h0B0A0908);
        check("fr_addr3", log_addr(base + 3), 32'd3);
        check("fr_data3", log_data(base + 3), 32'h0F0E0D0C);
        check("fr_done_cnt", 32'(done_cnt), 32'd1);
        last = wr_cyc_log.size() - 1;
        check("fr_done_delay", 32'(done_cyc - ((last >= 0) ? wr_cyc_log[last] : 0)), 32'd1);
        check("fr_done_busy", 32'(done_busy), 32'd0);
        check("fr_busy_end", 32'(busy), 32'd0);

        // Frame error between bytes 1 and 2
        pulse(1'b1, 1'b0);
        base = wr_data_log.size();
        send_byte(8'hA1, 1'b1);
        send_byte(8'h5A, 1'b0);
        check("fe_set", 32'(frame_err), 32'd1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hD4, 1'b1);
        idle_bits(2);
        check("fe_count", 32'(wr_data_log.size() - base), 32'd1);
        check("fe_addr", log_addr(base), 32'd0);
        check("fe_data", log_data(base), 32'hD4C3B2A1);
        check("fe_sticky", 32'(frame_err), 32'd1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check("fe_cleared", 32'(frame_err), 32'd0);

        // Quarter-bit glitch must not produce a byte
        base = wr_data_log.size();
        drive_bit(1'b0, CPB / 4);
        idle_bits(3);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle_bits(2);
        check("gl_count", 32'(wr_data_log.size() - base), 32'd1);
        check("gl_data", log_data(base), 32'h04030201);

        // STOP after 6 bytes, then restart
        base = wr_data_log.size();
        for (int i = 0; i < 6; i++) begin
            b = 8'h10 + 8'(i);
            send_byte(b, 1'b1);
        end
        idle_bits(1);
        check("st_mid_addr", log_addr(base), 32'd1);
        check("st_mid_data", log_data(base), 32'h13121110);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        idle_bits(2);
        check("st_count", 32'(wr_data_log.size() - base), 32'd2);
        check("st_addr", 32'(wr_addr), 32'd0);
        check("st_data", wr_data, 32'hDDCCBBAA);

        // START and STOP together: STOP wins; bytes ignored in IDLE
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check("ss_busy", 32'(busy), 32'd0);
        base = wr_data_log.size();
        for (int i = 0; i < 4; i++) send_byte(8'h99, 1'b1);
        idle_bits(2);
        check("ss_no_write", 32'(wr_data_log.size() - base), 32'd0);

        // START during LOAD is ignored
        pulse(1'b1, 1'b0);
        base = wr_data_log.size();
        send_byte(8'h21, 1'b1);
        send_byte(8'h22, 1'b1);
        pulse(1'b1, 1'b0);
        send_byte(8'h23, 1'b1);
        send_byte(8'h24, 1'b1);
        idle_bits(2);
        check("rs_addr", log_addr(base), 32'd0);
        check("rs_data", log_data(base), 32'h24232221);

`ifdef RX_TIMEOUT_EN
        // Partial word discarded after idle timeout
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        base = wr_data_log.size();
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle_bits(41);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle_bits(2);
        check("to_count", 32'(wr_data_log.size() - base), 32'd1);
        check("to_addr", log_addr(base), 32'd0);
        check("to_data", log_data(base), 32'h04030201);
`endif

        // Reset mid-byte with a partial word and FRAME_ERR set
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        send_byte(8'h77, 1'b1);
        send_byte(8'h55, 1'b0);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB / 2);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        check("mr_frame_err", 32'(frame_err), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_wr_addr", 32'(wr_addr), 32'd0);
        check("mr_wr_data", wr_data, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0);
        base = wr_data_log.size();
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        send_byte(8'h63, 1'b1);
        send_byte(8'h64, 1'b1);
        idle_bits(2);
        check("mr_count", 32'(wr_data_log.size() - base), 32'd1);
        check("mr_addr", log_addr(base), 32'd0);
        check("mr_data", log_data(base), 32'h64636261);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_loader.md
# uart_rx_loader

Receive-side counterpart of the beamformer UART streaming path. Samples the UART RX line, assembles incoming bytes into 32-bit words (first byte in bits [7:0]), and writes each completed word into the coefficient/sample dual-port RAM at sequential word addresses 0..NUM_WORDS-1. Sits between the board UART_RXD pin and the RAM write port, alongside the existing TX streaming logic on the same CLOCK domain.

## Interface
- CLKS_PER_BIT, 434, CLOCK cycles per UART bit (50 MHz / 115200).
- NUM_WORDS, 768, words per frame; load ends after word NUM_WORDS-1.
- ADDR_W, 12, RAM word address width; NUM_WORDS ≤ 2^ADDR_W.
- TIMEOUT_BITS, 40, idle bit-times before a partial word is discarded (used only with RX_TIMEOUT_EN).

- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- UART_RXD  in  1  asynchronous serial input, idle high, 8N1, LSB first.
- START  in  1  level/pulse; arms a frame load from word 0.
- STOP  in  1  level/pulse; aborts the load, returns to IDLE.
- WR_EN  out  1  one-cycle RAM write strobe.
- WR_ADDR  out  ADDR_W  RAM word address, valid with WR_EN.
- WR_DATA  out  32  assembled word, valid with WR_EN.
- BUSY  out  1  high while in LOAD.
- DONE  out  1  one-cycle pulse after final word written.
- FRAME_ERR  out  1  sticky; a byte with a low stop bit was received.

## Operation
- Bit sampler (sub-module): 2-FF synchronizer on UART_RXD; falling edge while idle starts a bit timer; re-check at CLKS_PER_BIT/2 — if high, false start, return to idle. Then sample each data bit and the stop bit at CLKS_PER_BIT intervals from that midpoint. After stop-bit sample: stop=1 → one-cycle byte_valid with byte; stop=0 → byte_err pulse, no byte_valid. Sampler runs regardless of loader state.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE: bytes ignored. START → LOAD, word address 0, lane 0, FRAME_ERR cleared.
  - LOAD: byte_valid stores byte into lane (lane 0 → [7:0] … lane 3 → [31:24]), lane increments mod 4. On lane 3 store: WR_EN pulses, WR_ADDR = current word address, WR_DATA = full word; address increments. Write of address NUM_WORDS-1 → DONE.
  - DONE: DONE high one cycle, → IDLE.
- byte_err: FRAME_ERR set, byte discarded, lane unchanged.
- STOP in any state: → IDLE, lane and address cleared, partial word discarded, no WR_EN. STOP and START same cycle: STOP wins.
- START while in LOAD: ignored (no restart).
- WR_ADDR holds last written address between writes; WR_DATA holds last word.

## Timing
- Reset values: WR_EN 0, WR_ADDR 0, WR_DATA 0, BUSY 0, DONE 0, FRAME_ERR 0; FSM IDLE, lane 0, sampler idle.
- byte_valid: 1 cycle after stop-bit mid-sample (~9.5 bit times after start edge + 2 synchronizer cycles).
- WR_EN: cycle after 4th byte_valid of a word. DONE: cycle after final WR_EN. BUSY falls with DONE.
- Reset mid-byte or mid-frame: everything returns to reset values immediately; next byte needs a fresh start edge.
- Back-to-back bytes with zero idle between stop and next start must be received without loss.

## Configuration
- RX_TIMEOUT_EN defined: in LOAD with lane ≠ 0, if no byte_valid for TIMEOUT_BITS×CLKS_PER_BIT cycles, partial word discarded and lane → 0; address unchanged, FRAME_ERR unaffected.
- Undefined: no timeout counter; partial word waits indefinitely.

## Structure
- Shared package uart_pkg: loader state enum (IDLE/LOAD/DONE), CLKS_PER_BIT default, NUM_WORDS default, ADDR_W default.
- One sub-module: uart_rx_core (synchronizer, bit timer, shift register, byte_valid/byte_err). Loader FSM, lane/address counters, and timeout in uart_rx_loader.

## Test plan
- Reset, START, send bytes 0x11,0x22,0x33,0x44 → one WR_EN, WR_ADDR 0, WR_DATA 0x44332211; BUSY stays 1.
- Full frame with NUM_WORDS=4, 16 bytes 0x00..0x0F back-to-back → WR_EN at addresses 0..3, word 3 = 0x0F0E0D0C, DONE one cycle after 4th WR_EN, BUSY 0.
- Byte with stop bit 0 between bytes 1 and 2 of a word → FRAME_ERR 1, next good bytes complete the word with the bad byte absent; next START clears FRAME_ERR.
- 0.25-bit low glitch on UART_RXD → no byte_valid, no WR_EN.
- STOP after 6 bytes, then START and 4 bytes 0xAA,0xBB,0xCC,0xDD → WR_ADDR 0, WR_DATA 0xDDCCBBAA; same-cycle START+STOP leaves BUSY 0.
- With RX_TIMEOUT_EN, TIMEOUT_BITS=40: 2 bytes, idle 41 bit times, 4 bytes 0x01..0x04 → WR_DATA 0x04030201 at address 0.
